// File: rtl/nios_system_irq_ctrl.sv
// Interrupt aggregator: synchronises request lines, latches them per line as level or
// rising-edge, masks them and presents one registered request plus a lowest-index vector.
module nios_system_irq_ctrl #(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_out,
  output logic [3:0]         irq_id
);

  localparam logic [15:0] LINE_MASK = 16'((32'd1 << NUM_IRQ) - 32'd1);

  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] r_sync;
  logic [15:0] r_hist;
  logic [15:0] r_pend;
  logic [15:0] r_mask;
  logic [15:0] r_edge;
  logic        r_irq_out;
  logic [3:0]  r_irq_id;
  logic [15:0] r_readdata;

  logic        w_wr;
  logic [15:0] w_wdata;
  logic [15:0] w_sync;
  logic [15:0] w_rise;
  logic [15:0] w_clr;
  logic [15:0] w_swi;
  logic [15:0] w_mode_flip;
  logic [15:0] w_pend_edge;
  logic [15:0] w_pend_nxt;
  logic [15:0] w_active;
  logic [3:0]  w_id;
  logic [15:0] w_rdata;

  // Bits above NUM_IRQ are stripped here so every register stays zero there.
  assign w_wr        = chipselect & ~write_n;
  assign w_wdata     = writedata & LINE_MASK;
  assign w_sync      = 16'(r_sync[SYNC_STAGES-1]);
  assign w_rise      = w_sync & ~r_hist;
  assign w_clr       = (w_wr && address == 3'd1) ? w_wdata : 16'h0000;
  assign w_swi       = (w_wr && address == 3'd6) ? w_wdata : 16'h0000;
  assign w_mode_flip = (w_wr && address == 3'd3) ? (w_wdata ^ r_edge) : 16'h0000;

  // Set terms are OR-ed after the clear so a coincident event is never lost.
  assign w_pend_edge = (r_pend & ~w_clr) | w_rise | w_swi;
  assign w_pend_nxt  = LINE_MASK & ~w_mode_flip &
                       ((r_edge & w_pend_edge) | (~r_edge & w_sync));
  assign w_active    = r_pend & r_mask;

  always_comb begin
    w_id = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_active[i]) w_id = 4'(i);
    end
  end

  always_comb begin
    w_rdata = 16'h0000;
    case (address)
      3'd0:    w_rdata = w_sync;
      3'd1:    w_rdata = r_pend;
      3'd2:    w_rdata = r_mask;
      3'd3:    w_rdata = r_edge;
      3'd4:    w_rdata = w_active;
      3'd5:    w_rdata = {r_irq_out, 11'b0, r_irq_id};
      default: w_rdata = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync     <= '0;
      r_hist     <= 16'h0000;
      r_pend     <= 16'h0000;
      r_mask     <= 16'h0000;
      r_edge     <= 16'h0000;
      r_irq_out  <= 1'b0;
      r_irq_id   <= 4'd0;
      r_readdata <= 16'h0000;
    end else begin
      r_sync[0] <= irq_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
      r_hist     <= w_sync;
      r_pend     <= w_pend_nxt;
      if (w_wr && address == 3'd2) r_mask <= w_wdata;
      if (w_wr && address == 3'd3) r_edge <= w_wdata;
      r_irq_out  <= |w_active;
      r_irq_id   <= w_id;
      r_readdata <= w_rdata;
    end
  end

  assign readdata = r_readdata;
  assign irq_out  = r_irq_out;
  assign irq_id   = r_irq_id;

endmodule
